// File: rtl/mult32x32_fsm.sv
// Control FSM for the byte-serial 32x32 multiplier: sequences eight 8x16 partial
// products into the downstream product register and pulses done at the end.
module mult32x32_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [1:0] a_sel,
   output logic       b_sel,
   output logic [2:0] shift_sel,
   output logic       upd_prod,
   output logic       clr_prod
);

   typedef enum logic [3:0] {
      StIdle = 4'd0,
      StA0B0 = 4'd1,
      StA1B0 = 4'd2,
      StA2B0 = 4'd3,
      StA3B0 = 4'd4,
      StA0B1 = 4'd5,
      StA1B1 = 4'd6,
      StA2B1 = 4'd7,
      StA3B1 = 4'd8
   } state_e;

   state_e     state_q, state_d;
   logic       done_q, done_d;
   logic       step_valid;
   logic [2:0] step;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // Unused encodings fall through to the default and return to idle.
   always_comb begin
      state_d = StIdle;
      case (state_q)
         StIdle:  state_d = start ? StA0B0 : StIdle;
         StA0B0:  state_d = StA1B0;
         StA1B0:  state_d = StA2B0;
         StA2B0:  state_d = StA3B0;
         StA3B0:  state_d = StA0B1;
         StA0B1:  state_d = StA1B1;
         StA1B1:  state_d = StA2B1;
         StA2B1:  state_d = StA3B1;
         StA3B1:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      done_d = (state_q == StA3B1);
   end

   // step[1:0] is the A byte, step[2] the B half.
   always_comb begin
      step_valid = 1'b1;
      step       = 3'd0;
      case (state_q)
         StA0B0:  step = 3'd0;
         StA1B0:  step = 3'd1;
         StA2B0:  step = 3'd2;
         StA3B0:  step = 3'd3;
         StA0B1:  step = 3'd4;
         StA1B1:  step = 3'd5;
         StA2B1:  step = 3'd6;
         StA3B1:  step = 3'd7;
         default: step_valid = 1'b0;
      endcase
      busy      = step_valid;
      upd_prod  = step_valid;
      a_sel     = step[1:0];
      b_sel     = step[2];
      shift_sel = {1'b0, step[1:0]} + {1'b0, step[2], 1'b0};
      // Qualified by reset so start cannot clear the product while held in reset.
      clr_prod  = (state_q == StIdle) && start && reset;
      done      = done_q;
   end

endmodule

// File: tb/tb_mult32x32_fsm.sv
// Bench for mult32x32_fsm with a behavioural arithmetic unit and a product
// scoreboard keyed on the cycle in which done is due.
module tb_mult32x32_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy, done, b_sel, upd_prod, clr_prod;
   logic [1:0]  a_sel;
   logic [2:0]  shift_sel;
   logic [31:0] a, b;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int step   = 0;

   typedef struct {
      logic [63:0] prod;
      int          due;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [5:0]  seq_tab [8];
   logic [63:0] prod, pp;
   logic [7:0]  a_byte;
   logic [15:0] b_half;

   mult32x32_fsm dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .a_sel     (a_sel),
      .b_sel     (b_sel),
      .shift_sel (shift_sel),
      .upd_prod  (upd_prod),
      .clr_prod  (clr_prod)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Arithmetic unit stand-in, reset through an inverter as in the real system.
   always_comb begin
      a_byte = a[8*int'(a_sel) +: 8];
      b_half = b[16*int'(b_sel) +: 16];
      pp     = ({56'd0, a_byte} * {48'd0, b_half}) << (8 * int'(shift_sel));
   end

   always @(posedge clk or negedge reset) begin
      if (!reset)        prod <= 64'd0;
      else if (clr_prod) prod <= 64'd0;
      else if (upd_prod) prod <= prod + pp;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         check("rst_busy", {63'd0, busy}, 64'd0);
         check("rst_done", {63'd0, done}, 64'd0);
         check("rst_upd", {63'd0, upd_prod}, 64'd0);
         check("rst_clr", {63'd0, clr_prod}, 64'd0);
         check("rst_sel", {58'd0, a_sel, b_sel, shift_sel}, 64'd0);
         step = 0;
      end else begin
         if (busy) begin
            if (step < 8) check("seq", {58'd0, a_sel, b_sel, shift_sel}, {58'd0, seq_tab[step]});
            else          check("busy_too_long", 64'(step), 64'd7);
            check("busy_upd", {63'd0, upd_prod}, 64'd1);
            check("busy_clr", {63'd0, clr_prod}, 64'd0);
            step++;
         end else begin
            if (step != 0) begin
               check("busy_len", 64'(step), 64'd8);
               step = 0;
            end
            check("idle_upd", {63'd0, upd_prod}, 64'd0);
            check("idle_sel", {58'd0, a_sel, b_sel, shift_sel}, 64'd0);
            check("idle_clr", {63'd0, clr_prod}, {63'd0, start});
         end
         if (done) begin
            if (sb.size() == 0) begin
               check("done_spurious", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("done_time", 64'(cyc), 64'(e.due));
               check("product", prod, e.prod);
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            check("done_missing", 64'd0, 64'd1);
            e = sb.pop_front();
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Start is sampled at the next edge; done is due nine cycles after this one.
   task automatic issue(input logic [31:0] x, input logic [31:0] y);
      a     = x;
      b     = y;
      start = 1'b1;
      sb.push_back('{prod: {32'd0, x} * {32'd0, y}, due: cyc + 9});
   endtask

   task automatic run_single(input logic [31:0] x, input logic [31:0] y);
      issue(x, y);
      tick(1);
      start = 1'b0;
      tick(10);
   endtask

   initial begin
      seq_tab[0] = {2'd0, 1'b0, 3'd0};
      seq_tab[1] = {2'd1, 1'b0, 3'd1};
      seq_tab[2] = {2'd2, 1'b0, 3'd2};
      seq_tab[3] = {2'd3, 1'b0, 3'd3};
      seq_tab[4] = {2'd0, 1'b1, 3'd2};
      seq_tab[5] = {2'd1, 1'b1, 3'd3};
      seq_tab[6] = {2'd2, 1'b1, 3'd4};
      seq_tab[7] = {2'd3, 1'b1, 3'd5};

      // Reset held with start high: nothing may move, clr_prod included.
      reset = 1'b0;
      start = 1'b1;
      a     = 32'd0;
      b     = 32'd0;
      tick(3);
      reset = 1'b1;
      start = 1'b0;
      tick(3);

      run_single(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_single(32'h1234_5678, 32'h9ABC_DEF0);
      run_single(32'd0, 32'hDEAD_BEEF);

      // Start pulse during busy cycle 3 must be ignored.
      issue(32'hCAFE_F00D, 32'h0BAD_CAB1);
      tick(1);
      start = 1'b0;
      tick(2);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(10);

      // Back-to-back with start held; operands change in each done cycle.
      issue($urandom, $urandom);
      for (int k = 0; k < 4; k++) begin
         tick(9);
         if (k < 3) issue($urandom, $urandom);
      end
      start = 1'b0;
      tick(10);

      // Reset during busy cycle 5 abandons the operation without done.
      issue(32'h8000_0001, 32'h7FFF_FFFF);
      tick(1);
      start = 1'b0;
      tick(4);
      #2;
      reset = 1'b0;
      #1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_upd", {63'd0, upd_prod}, 64'd0);
      sb.delete();
      tick(2);
      // Release with start already high counts as a start at the next edge.
      issue(32'd7, 32'd6);
      reset = 1'b1;
      tick(1);
      start = 1'b0;
      tick(12);

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult32x32_fsm.md
# mult32x32_fsm

Control unit for the 32x32 byte-serial multiplier. It sits directly upstream of the multiplier arithmetic unit and drives that unit's `a_sel`, `b_sel`, `shift_sel`, `upd_prod` and `clr_prod` inputs. On `start` it sequences the eight 8x16 partial products into the product register, then reports completion. The block holds no datapath; operands `a`/`b` go straight to the arithmetic unit and must stay stable while `busy`.

## Interface
No parameters. Sequence length, operand widths and select encodings are fixed by the arithmetic unit.

Ports:
- `clk`  in  1  rising-edge clock, single domain
- `reset`  in  1  asynchronous, active-low; 0 forces IDLE immediately
- `start`  in  1  request a multiplication; sampled only in IDLE
- `busy`  out  1  1 while a sequence is in progress
- `done`  out  1  one-cycle pulse: product register holds the final result
- `a_sel`  out  2  byte of A selected for the current partial product
- `b_sel`  out  1  16-bit half of B selected for the current partial product
- `shift_sel`  out  3  left shift of the partial product, in units of 8 bits
- `upd_prod`  out  1  accumulate the partial product into the product register this edge
- `clr_prod`  out  1  clear the product register this edge

## Operation
- States: IDLE, then the step states S_A0B0, S_A1B0, S_A2B0, S_A3B0, S_A0B1, S_A1B1, S_A2B1, S_A3B1, in that fixed order.
- IDLE:
  - `busy`=0, `upd_prod`=0, selects=0.
  - `clr_prod`=`start` (Mealy output).
  - `start`=1 moves to S_A0B0; otherwise stay in IDLE.
- Step state SAiBj:
  - `a_sel`=i, `b_sel`=j, `shift_sel`=i+2j (range 0..5; 6 and 7 are never driven).
  - `upd_prod`=1, `clr_prod`=0, `busy`=1.
  - Advance unconditionally to the next step state. S_A3B1 returns to IDLE.
- `start` is ignored while in any step state. No queuing: a request made while busy is lost.
- `done` is a register. It is set on the edge that leaves S_A3B1 and cleared on the next edge, so it is high exactly one cycle, the first IDLE cycle after a sequence.
- Next-state logic and outputs decode the state register only (plus `start` for `clr_prod`/exit from IDLE). Any unused state encoding goes to IDLE on the next edge.
- Result: product = Σ (A byte i × B half j) << (8i+16j) = a×b (unsigned, 64-bit). No overflow is possible.

## Timing
- Reset:
  - reset=0 asynchronously forces state=IDLE, `done`=0, `busy`=0, `upd_prod`=0, all selects=0.
  - `clr_prod` is forced to 0 while reset=0, regardless of `start`.
- Latency: `start` sampled high at edge E0 (product cleared at E0). Step states occupy cycles after E0..E7. Accumulates occur at E1..E8. The product is final after E8, and `done`=1 in the cycle after E8. Start to done is 9 cycles.
- `busy` is high for exactly 8 cycles per operation.
- Back-to-back: `start`=1 in the `done` cycle is accepted. `clr_prod` and `done` are then both high that cycle; the consumer must capture the product in that cycle, before the edge that clears it.
- Reset mid-sequence: the sequence is abandoned immediately and `done` is not produced. After release, the block waits for a new `start`.
- Release of reset with `start` already high: treated as a normal start at the first edge after release.

## Test plan
- Reset then idle: hold reset=0 for 3 cycles with `start`=1. Expect all outputs 0, including `clr_prod`. After release, no `upd_prod` until the first sampled `start`.
- Sequence check: single `start` pulse. Expect (`a_sel`,`b_sel`,`shift_sel`) on the 8 busy cycles = (0,0,0),(1,0,1),(2,0,2),(3,0,3),(0,1,2),(1,1,3),(2,1,4),(3,1,5), with `upd_prod`=1 on all 8. Expect `done` high exactly 1 cycle, 9 cycles after start.
- Integrated with the arithmetic unit (via an inverter to its active-high reset): a=0xFFFFFFFF, b=0xFFFFFFFF gives product 0xFFFFFFFE00000001 at `done`. a=0x12345678, b=0x9ABCDEF0 gives 0x0B00EA4E242D2080.
- Start while busy: pulse `start` at busy cycle 3. Expect no restart, no `clr_prod`, and a single `done` at the original time.
- Back-to-back: hold `start`=1 continuously. Expect `done` every 9 cycles, `clr_prod` coincident with each `done`, and a correct product each time.
- Reset mid-sequence: assert reset during busy cycle 5. Expect IDLE immediately, no `done`. Then a new `start` with a=7, b=6 gives product 42.
